// File: rtl/pong_timing_pkg.sv
// Pong video timing constants and shared count type.
// Defaults match the discrete NTSC Pong line and frame timing.
package pong_timing_pkg;
  localparam int CNT_W = 9;

  localparam int H_TOTAL_D      = 455;
  localparam int H_BLANK_END_D  = 80;
  localparam int H_SYNC_START_D = 32;
  localparam int H_SYNC_END_D   = 64;

  localparam int V_TOTAL_D      = 262;
  localparam int V_BLANK_END_D  = 16;
  localparam int V_SYNC_START_D = 4;
  localparam int V_SYNC_END_D   = 8;

  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/pong_sync_counter.sv
// Modulo counter with terminal decode and JK-style blank/sync flops.
// Flags update from the next count so they always agree with it.
module sync_counter
  import pong_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL_D,
  parameter int BLANK_END  = H_BLANK_END_D,
  parameter int SYNC_START = H_SYNC_START_D,
  parameter int SYNC_END   = H_SYNC_END_D
) (
  input  logic clk,
  input  logic _clr,
  input  logic i_adv,
  output cnt_t o_cnt,
  output logic o_tc,
  output logic o_blank,
  output logic o_sync_n
);

  if (!(0 < SYNC_START && SYNC_START < SYNC_END &&
        SYNC_END <= BLANK_END && BLANK_END < TOTAL &&
        TOTAL <= 512)) begin : g_bad_params
    $error("sync_counter: bad timing parameters");
  end

  cnt_t r_cnt;
  logic r_blank;
  logic r_sync_n;
  logic w_tc;
  cnt_t w_nxt;

  assign w_tc  = (r_cnt == cnt_t'(TOTAL - 1));
  assign w_nxt = w_tc ? '0 : r_cnt + cnt_t'(1);

  always_ff @(posedge clk or negedge _clr) begin
    if (!_clr) begin
      r_cnt    <= '0;
      r_blank  <= 1'b1;
      r_sync_n <= 1'b1;
    end else if (i_adv) begin
      r_cnt <= w_nxt;
      if (w_nxt == '0)
        r_blank <= 1'b1;
      else if (w_nxt == cnt_t'(BLANK_END))
        r_blank <= 1'b0;
      if (w_nxt == cnt_t'(SYNC_START))
        r_sync_n <= 1'b0;
      else if (w_nxt == cnt_t'(SYNC_END))
        r_sync_n <= 1'b1;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_tc     = w_tc;
  assign o_blank  = r_blank;
  assign o_sync_n = r_sync_n;

endmodule

// File: rtl/pong_sync_gen.sv
// Pong H/V timing generator: two chained sync_counter instances.
// V advances only on ce edges that land on the H terminal count.
module pong_sync_gen
  import pong_timing_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_D,
  parameter int H_BLANK_END  = H_BLANK_END_D,
  parameter int H_SYNC_START = H_SYNC_START_D,
  parameter int H_SYNC_END   = H_SYNC_END_D,
  parameter int V_TOTAL      = V_TOTAL_D,
  parameter int V_BLANK_END  = V_BLANK_END_D,
  parameter int V_SYNC_START = V_SYNC_START_D,
  parameter int V_SYNC_END   = V_SYNC_END_D
) (
  input  logic clk,
  input  logic _clr,
  input  logic ce,
  output cnt_t hcount,
  output cnt_t vcount,
  output logic hreset,
  output logic vreset,
  output logic hblank,
  output logic vblank,
  output logic hsync_n,
  output logic vsync_n
);

  logic w_hreset;
  logic w_vtc;
  logic w_vadv;

  assign w_vadv = ce & w_hreset;

  sync_counter #(
    .TOTAL      (H_TOTAL),
    .BLANK_END  (H_BLANK_END),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END)
  ) u_h (
    .clk      (clk),
    ._clr     (_clr),
    .i_adv    (ce),
    .o_cnt    (hcount),
    .o_tc     (w_hreset),
    .o_blank  (hblank),
    .o_sync_n (hsync_n)
  );

  sync_counter #(
    .TOTAL      (V_TOTAL),
    .BLANK_END  (V_BLANK_END),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END)
  ) u_v (
    .clk      (clk),
    ._clr     (_clr),
    .i_adv    (w_vadv),
    .o_cnt    (vcount),
    .o_tc     (w_vtc),
    .o_blank  (vblank),
    .o_sync_n (vsync_n)
  );

  assign hreset = w_hreset;
  assign vreset = w_vtc & w_hreset;

endmodule

// File: tb/tb_pong_sync_gen.sv
// Scoreboard bench for pong_sync_gen against a count-decode model.
// V_TOTAL is shortened so a full frame stays within the cycle budget.
module tb_pong_sync_gen;
  import pong_timing_pkg::*;

  localparam int HT  = 455;
  localparam int HBE = 80;
  localparam int HSS = 32;
  localparam int HSE = 64;
  localparam int VT  = 24;
  localparam int VBE = 16;
  localparam int VSS = 4;
  localparam int VSE = 8;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic       hr;
    logic       vr;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
  } vec_t;

  logic clk = 1'b0;
  logic _clr = 1'b0;
  logic ce = 1'b0;
  cnt_t hcount;
  cnt_t vcount;
  logic hreset;
  logic vreset;
  logic hblank;
  logic vblank;
  logic hsync_n;
  logic vsync_n;

  int n_vec = 0;
  int n_err = 0;
  int mh = 0;
  int mv = 0;
  vec_t sb[$];

  always #5 clk = ~clk;

  pong_sync_gen #(
    .H_TOTAL      (HT),
    .H_BLANK_END  (HBE),
    .H_SYNC_START (HSS),
    .H_SYNC_END   (HSE),
    .V_TOTAL      (VT),
    .V_BLANK_END  (VBE),
    .V_SYNC_START (VSS),
    .V_SYNC_END   (VSE)
  ) dut (
    .clk     (clk),
    ._clr    (_clr),
    .ce      (ce),
    .hcount  (hcount),
    .vcount  (vcount),
    .hreset  (hreset),
    .vreset  (vreset),
    .hblank  (hblank),
    .vblank  (vblank),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n)
  );

  function automatic vec_t model_vec(int h, int v, bit in_rst);
    vec_t e;
    e.h  = 9'(h);
    e.v  = 9'(v);
    e.hr = !in_rst && (h == HT - 1);
    e.vr = !in_rst && (h == HT - 1) && (v == VT - 1);
    e.hb = (h < HBE);
    e.vb = (v < VBE);
    e.hs = !(h >= HSS && h < HSE);
    e.vs = !(v >= VSS && v < VSE);
    return e;
  endfunction

  function automatic vec_t dut_vec();
    vec_t o;
    o = '{hcount, vcount, hreset, vreset,
          hblank, vblank, hsync_n, vsync_n};
    return o;
  endfunction

  task automatic pop_cmp(string name);
    vec_t e;
    vec_t o;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    o = dut_vec();
    if (o !== e) begin
      n_err++;
      $display("FAIL %s: got %h required %h (h=%0d v=%0d)",
               name, o, e, e.h, e.v);
    end
  endtask

  task automatic step(bit ce_v, string name);
    ce = ce_v;
    if (ce_v) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    sb.push_back(model_vec(mh, mv, 1'b0));
    @(posedge clk);
    #1;
    pop_cmp(name);
  endtask

  task automatic test_reset();
    _clr = 1'b0;
    ce = 1'b1;
    @(posedge clk);
    #1;
    mh = 0;
    mv = 0;
    sb.push_back(model_vec(0, 0, 1'b1));
    pop_cmp("reset_state");
    _clr = 1'b1;
    step(1'b1, "reset_release");
  endtask

  task automatic test_line_wrap();
    while (mh < HT - 1) step(1'b1, "line_run");
    if (hreset !== 1'b1 || hcount !== 9'(HT - 1)) begin
      n_err++;
      $display("FAIL line_hreset: hreset=%b h=%0d required 1 h=%0d",
               hreset, hcount, HT - 1);
    end
    n_vec++;
    step(1'b1, "line_wrap");
    if (hcount !== 9'd0 || vcount !== 9'd1 || hblank !== 1'b1) begin
      n_err++;
      $display("FAIL line_wrap_state: h=%0d v=%0d hb=%b required 0 1 1",
               hcount, vcount, hblank);
    end
    n_vec++;
  endtask

  task automatic test_hflags();
    for (int i = 0; i < HT; i++) step(1'b1, "hflags");
  endtask

  task automatic test_frame_wrap();
    int pulses = 0;
    int budget = HT * VT + 10;
    do begin
      step(1'b1, "frame_run");
      if (vreset === 1'b1) pulses++;
      budget--;
    end while (!(mh == 0 && mv == 0) && budget > 0);
    n_vec++;
    if (budget == 0) begin
      n_err++;
      $display("FAIL frame_budget: frame wrap not reached");
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL frame_vreset: %0d pulses required 1", pulses);
    end
    for (int i = 0; i < 2 * HT; i++) step(1'b1, "frame_post");
  endtask

  task automatic test_clock_enable();
    int v0;
    while (mh != HT - 1) step(1'b1, "ce_run");
    v0 = mv;
    for (int i = 0; i < 50; i++) step(1'b0, "ce_hold");
    step(1'b1, "ce_resume");
    n_vec++;
    if (vcount !== 9'((v0 + 1) % VT)) begin
      n_err++;
      $display("FAIL ce_vadvance: v=%0d required %0d",
               vcount, (v0 + 1) % VT);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), "random_ce");
  endtask

  task automatic test_reset_midline();
    int budget = HT * VT + 10;
    while (!(mh == 200 && mv == 20) && budget > 0) begin
      step(1'b1, "mid_run");
      budget--;
    end
    ce = 1'b1;
    #2;
    _clr = 1'b0;
    #1;
    mh = 0;
    mv = 0;
    sb.push_back(model_vec(0, 0, 1'b1));
    pop_cmp("reset_midline");
    #1;
    _clr = 1'b1;
    step(1'b1, "mid_release");
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_hflags();
    test_frame_wrap();
    test_clock_enable();
    test_back_to_back();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
